dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-requester round-robin arbiter for the single data-memory port (data_mem).
//   Requester 0 is the CPU data side; requester 1 is a debug/loader master.
//   Accepted requests are registered and issued as one access per transaction.
//   Read data and completion are returned to the owning requester only.
//   mem_* are split read/write buses; the top level merges them onto the shared data bus.
// PARAMETERS
//   AW   64  address width (bits), matches `WORD
//   DW   64  data width (bits), matches `WORD
// PORTS
//   clk         in   1   system clock, all state on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   m0_req      in   1   requester 0 access request (level)
//   m0_we       in   1   1 = write, 0 = read
//   m0_addr     in   AW  byte address
//   m0_wdata    in   DW  write data
//   m0_gnt      out  1   one-cycle pulse: request accepted
//   m0_done     out  1   one-cycle pulse: access completed
//   m0_rdata    out  DW  read data, valid while m0_done=1 for a read
//   m1_*        -    -   identical set for requester 1
//   mem_read    out  1   memory read strobe (MemRead)
//   mem_write   out  1   memory write strobe (MemWrite), write on rising clk
//   mem_addr    out  AW  memory address
//   mem_wdata   out  DW  memory write data
//   mem_rdata   in   DW  memory read data, combinational from mem_addr/mem_read
// BEHAVIOUR
//   Reset: state=IDLE, last=1 (requester 0 wins first tie). All outputs 0; addr/wdata/rdata regs 0.
//   States: IDLE, ACCESS, RESP.
//   Arbitration (in IDLE and RESP): if exactly one req -> grant it; if both -> grant the
//     requester != last. On grant: latch we/addr/wdata, set owner, last=owner, pulse mX_gnt,
//     next state ACCESS. No req -> IDLE.
//   ACCESS (1 cycle): mem_addr/mem_wdata from latched regs; mem_write=we, mem_read=!we;
//     for reads, capture mem_rdata into rdata reg at end of cycle. Next RESP.
//   RESP: pulse owner's mX_done; mX_rdata=captured data (reads) else 0. Re-arbitrate in the
//     same cycle; a grant goes straight to ACCESS (back-to-back rate: one access per 2 clk).
//   mem_read/mem_write are 0 outside ACCESS; never both 1.
//   Latency: req asserted in IDLE -> gnt same cycle (registered, seen next edge) -> access
//     next cycle -> done the cycle after.
//   Requester holds req/we/addr/wdata stable until gnt; req still high in cycle after gnt is a
//     new request. Non-owner's gnt/done/rdata stay 0.
//   Addresses pass unmodified; no alignment or range check.
//   Simultaneous new req from owner during RESP: treated like any req, round-robin applies.
//   Reset mid-transaction: all state cleared asynchronously, mem_write drops immediately,
//     in-flight access abandoned, no done pulse issued.
// TESTING
//   Reset: rst_n=0 mid-ACCESS write -> mem_write=0 at once, no m0_done, first tie after goes to m0.
//   Single read: m0 read addr 0x10, mem holds 0xDEADBEEF -> gnt c0, mem_read c1, m0_done+rdata c2.
//   Write then read: m1 writes 0x1234 to 0x20, then reads 0x20 -> m1_rdata=0x1234.
//   Contention: m0,m1 held high for 4 grants -> order m0,m1,m0,m1; one access per 2 clk.
//   Isolation: m1 read in flight -> m0_gnt/m0_done stay 0; m0_rdata=0 throughout.
//   Strobes: random traffic 1000 cycles -> mem_read&mem_write never both 1; assert outside ACCESS=0.

Source files
------------

// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
//   Request/response bundle between one data-memory requester and the
//   dmem_arbiter. The requester drives the request fields and holds them
//   stable until it sees gnt. The arbiter returns one-cycle gnt and done
//   pulses, and read data that is valid only while done is high.
//
//   Signals
//     req    requester -> arbiter  access request (level)
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  byte address (AW bits)
//     wdata  requester -> arbiter  write data (DW bits)
//     gnt    arbiter -> requester  one-cycle pulse, request accepted
//     done   arbiter -> requester  one-cycle pulse, access completed
//     rdata  arbiter -> requester  read data, valid while done=1 for a read
//
//   Modports
//     master  requester side
//     slave   arbiter side
// ----------------------------------------------------------------------------
interface dmem_if #(
   parameter int AW = 64,
   parameter int DW = 64
) ();
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          done;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, done, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester round-robin arbiter for the single data-memory port.
//   Requester 0 is the CPU data side and requester 1 is a debug/loader
//   master. An accepted request is latched and issued to memory as exactly
//   one access cycle, and its completion (plus read data) is returned only to
//   the requester that owns the transaction.
//
//   Ports
//     clk        system clock, all state on the rising edge
//     rst_n      asynchronous active-low reset
//     m0, m1     dmem_if.slave request/response bundles for requesters 0 / 1
//     mem_read   memory read strobe, only during the access cycle
//     mem_write  memory write strobe, only during the access cycle
//     mem_addr   memory address (latched request address)
//     mem_wdata  memory write data (latched request data)
//     mem_rdata  memory read data, combinational from mem_addr/mem_read
//
//   Transaction timing: gnt in the cycle the request is seen in IDLE or
//   RESP, the access cycle next, done the cycle after. A new grant can be
//   made in the RESP cycle, so back-to-back traffic runs at one access per
//   two clocks.
// ----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_if.slave         m0,
   dmem_if.slave         m1,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;

   logic          grant_valid;
   logic          grant_sel;

   logic          last;
   logic          owner;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;

   // State register. Reset drops straight back to IDLE, which abandons any
   // access in flight and suppresses its done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Arbitration and next-state logic. Arbitration is only open in IDLE and
   // RESP. On a tie the requester that did not win last time is chosen;
   // last resets to 1 so requester 0 wins the first tie.
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
      next_state  = IDLE;

      if (m0.req && m1.req) begin
         grant_sel = ~last;
      end else begin
         grant_sel = m1.req;
      end

      case (state)
         IDLE, RESP: begin
            grant_valid = m0.req || m1.req;
            next_state  = grant_valid ? ACCESS : IDLE;
         end
         ACCESS: begin
            next_state = RESP;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Transaction registers. The winning requester's fields are captured at
   // the grant so it may drop or change them afterwards; read data is
   // captured at the end of the access cycle because mem_rdata is only valid
   // while mem_read is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last    <= 1'b1;
         owner   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (grant_valid) begin
            owner   <= grant_sel;
            last    <= grant_sel;
            we_q    <= grant_sel ? m1.we    : m0.we;
            addr_q  <= grant_sel ? m1.addr  : m0.addr;
            wdata_q <= grant_sel ? m1.wdata : m0.wdata;
         end
         if ((state == ACCESS) && !we_q) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // Output decode. Strobes and the memory bus are only live in ACCESS, so
   // mem_read and mem_write are mutually exclusive by construction. The
   // response side is steered to the owner only; the other requester sees
   // zeros on gnt/done/rdata.
   always_comb begin
      m0.gnt    = grant_valid && !grant_sel;
      m1.gnt    = grant_valid &&  grant_sel;

      m0.done   = (state == RESP) && !owner;
      m1.done   = (state == RESP) &&  owner;

      m0.rdata  = ((state == RESP) && !owner && !we_q) ? rdata_q : '0;
      m1.rdata  = ((state == RESP) &&  owner && !we_q) ? rdata_q : '0;

      mem_read  = (state == ACCESS) && !we_q;
      mem_write = (state == ACCESS) &&  we_q;
      mem_addr  = (state == ACCESS) ? addr_q : '0;
      mem_wdata = ((state == ACCESS) && we_q) ? wdata_q : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A small 32-word memory sits on the
//   mem_* side. A transaction-level monitor follows every grant through its
//   access and response cycles, keeps a shadow copy of memory contents, and
//   checks strobes, addresses, done pulses, read data and round-robin
//   fairness on every falling edge. Directed sequences and a vector table
//   cover latency, write/read-back, contention, isolation and reset
//   mid-access; a randomized phase drives both requesters independently.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   int checks;
   int failures;

   dmem_if #(.AW(64), .DW(64)) m0_if ();
   dmem_if #(.AW(64), .DW(64)) m1_if ();

   dmem_arbiter #(.AW(64), .DW(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0        (m0_if),
      .m1        (m1_if),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] initVal(input int i);
      return (i == 2) ? 64'hDEADBEEF : (64'hA000 + 64'(i));
   endfunction

   // Behavioural memory: word indexed by address bits 7:3, reloaded while
   // reset is held, written on the rising edge, read combinationally.
   logic [63:0] mem [32];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= initVal(i);
      end else if (mem_write) begin
         mem[mem_addr[7:3]] <= mem_wdata;
      end
   end

   assign mem_rdata = mem_read ? mem[mem_addr[7:3]] : 64'd0;

   // Comparison helpers; both step the shared counters.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   function automatic logic gntOf(input bit m);
      return m ? m1_if.gnt : m0_if.gnt;
   endfunction

   function automatic logic doneOf(input bit m);
      return m ? m1_if.done : m0_if.done;
   endfunction

   function automatic logic [63:0] rdataOf(input bit m);
      return m ? m1_if.rdata : m0_if.rdata;
   endfunction

   task automatic drive(input bit m, input bit req, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
      if (m) begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
      end else begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
      end
   endtask

   // Transaction-level reference monitor. stage1 is the transaction granted
   // one cycle ago (its memory access is expected now), stage2 the one
   // granted two cycles ago (its done is expected now).
   typedef struct {
      bit          valid;
      bit          m;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } txn_t;

   txn_t        stage1;
   txn_t        stage2;
   bit          lastWin;
   logic [63:0] shadow [32];

   task automatic monitorLoop();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stage1.valid = 1'b0;
            stage2.valid = 1'b0;
            lastWin      = 1'b1;
            for (int i = 0; i < 32; i++) shadow[i] = initVal(i);
         end else begin
            txn_t cur;
            logic [63:0] exp0;
            logic [63:0] exp1;

            checkBit("gnt_exclusive", m0_if.gnt && m1_if.gnt, 1'b0);
            checkBit("strobe_exclusive", mem_read && mem_write, 1'b0);
            checkBit("strobe_window", mem_read || mem_write, stage1.valid);
            if (stage1.valid) begin
               checkBit("access_kind", mem_write, stage1.we);
               checkOutput("access_addr", mem_addr, stage1.addr);
               if (stage1.we) checkOutput("access_wdata", mem_wdata, stage1.wdata);
            end

            checkBit("done0", m0_if.done, stage2.valid && !stage2.m);
            checkBit("done1", m1_if.done, stage2.valid &&  stage2.m);
            exp0 = 64'd0;
            exp1 = 64'd0;
            if (stage2.valid && !stage2.we) begin
               if (stage2.m) exp1 = shadow[stage2.addr[7:3]];
               else          exp0 = shadow[stage2.addr[7:3]];
            end
            checkOutput("rdata0", m0_if.rdata, exp0);
            checkOutput("rdata1", m1_if.rdata, exp1);
            if (stage2.valid && stage2.we) shadow[stage2.addr[7:3]] = stage2.wdata;

            if (m0_if.gnt) checkBit("gnt0_needs_req", m0_if.req, 1'b1);
            if (m1_if.gnt) checkBit("gnt1_needs_req", m1_if.req, 1'b1);
            if ((m0_if.gnt || m1_if.gnt) && m0_if.req && m1_if.req)
               checkBit("rr_winner", m1_if.gnt, ~lastWin);

            cur.valid = m0_if.gnt || m1_if.gnt;
            cur.m     = m1_if.gnt;
            cur.we    = m1_if.gnt ? m1_if.we    : m0_if.we;
            cur.addr  = m1_if.gnt ? m1_if.addr  : m0_if.addr;
            cur.wdata = m1_if.gnt ? m1_if.wdata : m0_if.wdata;
            if (cur.valid) lastWin = cur.m;
            stage2 = stage1;
            stage1 = cur;
         end
      end
   endtask

   // One complete directed transaction: request, wait for grant (bounded),
   // release, wait for done (bounded) and return the delivered read data.
   task automatic applyStimulus(input bit m, input bit we, input logic [63:0] addr,
                                input logic [63:0] wdata, output logic [63:0] rdata, output bit ok);
      bit granted;
      bit finished;
      granted  = 1'b0;
      finished = 1'b0;
      rdata    = 64'd0;
      @(posedge clk); #1;
      drive(m, 1'b1, we, addr, wdata);
      for (int i = 0; i < 20 && !granted; i++) begin
         @(negedge clk);
         granted = gntOf(m);
      end
      @(posedge clk); #1;
      drive(m, 1'b0, 1'b0, 64'd0, 64'd0);
      for (int i = 0; i < 20 && granted && !finished; i++) begin
         @(negedge clk);
         if (doneOf(m)) begin
            finished = 1'b1;
            rdata    = rdataOf(m);
         end
      end
      ok = finished;
   endtask

   // Independent random requester: issues a request when idle, holds it
   // until granted, then waits for its own done before the next one.
   task automatic randDrive(input bit m, input int cycles);
      bit busy;
      bit granted;
      busy    = 1'b0;
      granted = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (gntOf(m))  granted = 1'b1;
         if (doneOf(m)) busy    = 1'b0;
         @(posedge clk); #1;
         if (granted) begin
            drive(m, 1'b0, 1'b0, 64'd0, 64'd0);
            granted = 1'b0;
         end
         if (!busy && ($urandom_range(0, 2) == 0)) begin
            busy = 1'b1;
            drive(m, 1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
         end
      end
      @(posedge clk); #1;
      drive(m, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   typedef struct {
      bit          m;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] expRdata;
   } vec_t;

   vec_t vecs[8];

   // Main test sequence.
   initial begin
      logic [63:0] rd;
      bit          ok;
      int          order [4];
      int          when [4];
      int          n;
      int          cyc;
      bit          gotG;
      bit          sawDone;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

      vecs[0] = '{1'b0, 1'b0, 64'h10, 64'h0,    64'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b1, 64'h20, 64'h1234, 64'h0};
      vecs[2] = '{1'b1, 1'b0, 64'h20, 64'h0,    64'h1234};
      vecs[3] = '{1'b0, 1'b1, 64'h48, 64'hA5A5, 64'h0};
      vecs[4] = '{1'b1, 1'b0, 64'h48, 64'h0,    64'hA5A5};
      vecs[5] = '{1'b0, 1'b0, 64'h20, 64'h0,    64'h1234};
      vecs[6] = '{1'b1, 1'b1, 64'h10, 64'hCAFE, 64'h0};
      vecs[7] = '{1'b0, 1'b0, 64'h10, 64'h0,    64'hCAFE};

      fork
         monitorLoop();
      join_none

      $display("[TB] reset state");
      repeat (2) @(negedge clk);
      checkBit("rst_mem_read", mem_read, 1'b0);
      checkBit("rst_mem_write", mem_write, 1'b0);
      checkOutput("rst_mem_addr", mem_addr, 64'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
      checkBit("rst_gnt0", m0_if.gnt, 1'b0);
      checkBit("rst_gnt1", m1_if.gnt, 1'b0);
      checkBit("rst_done0", m0_if.done, 1'b0);
      checkBit("rst_done1", m1_if.done, 1'b0);
      checkOutput("rst_rdata0", m0_if.rdata, 64'd0);
      checkOutput("rst_rdata1", m1_if.rdata, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      $display("[TB] single read latency");
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
      @(negedge clk);
      checkBit("lat_gnt_c0", m0_if.gnt, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      @(negedge clk);
      checkBit("lat_read_c1", mem_read, 1'b1);
      checkOutput("lat_addr_c1", mem_addr, 64'h10);
      checkBit("lat_nodone_c1", m0_if.done, 1'b0);
      @(negedge clk);
      checkBit("lat_done_c2", m0_if.done, 1'b1);
      checkOutput("lat_rdata_c2", m0_if.rdata, 64'hDEADBEEF);

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, ok);
         checkBit($sformatf("vec%0d_complete", i), ok, 1'b1);
         checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
      end

      $display("[TB] reset during write access");
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1, 64'h30, 64'h5555);
      @(negedge clk);
      checkBit("rst_mid_gnt", m0_if.gnt, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      #2;
      checkBit("rst_mid_write_before", mem_write, 1'b1);
      rst_n = 1'b0;
      #1;
      checkBit("rst_mid_write_drop", mem_write, 1'b0);
      checkOutput("rst_mid_addr_drop", mem_addr, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkBit("rst_mid_no_done0", m0_if.done, 1'b0);
      end

      $display("[TB] contention");
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 64'h10, 64'd0);
      drive(1'b1, 1'b1, 1'b0, 64'h20, 64'd0);
      n   = 0;
      cyc = 0;
      while (n < 4 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (m0_if.gnt || m1_if.gnt) begin
            order[n] = m1_if.gnt ? 1 : 0;
            when[n]  = cyc;
            n++;
         end
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      checkOutput("cont_grants", 64'(n), 64'd4);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("cont_order%0d", i), 64'(order[i]), 64'(i % 2));
         if (i > 0) checkOutput($sformatf("cont_spacing%0d", i), 64'(when[i] - when[i-1]), 64'd2);
      end
      repeat (4) @(negedge clk);

      $display("[TB] isolation");
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 64'h18, 64'd0);
      gotG    = 1'b0;
      sawDone = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkBit("iso_gnt0", m0_if.gnt, 1'b0);
         checkBit("iso_done0", m0_if.done, 1'b0);
         checkOutput("iso_rdata0", m0_if.rdata, 64'd0);
         if (m1_if.gnt) gotG = 1'b1;
         if (m1_if.done) begin
            sawDone = 1'b1;
            checkOutput("iso_rdata1", m1_if.rdata, 64'hA003);
         end
         @(posedge clk); #1;
         if (gotG) drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      end
      checkBit("iso_m1_done_seen", sawDone, 1'b1);

      $display("[TB] random traffic");
      fork
         randDrive(1'b0, 1000);
         randDrive(1'b1, 1000);
      join
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
